// File: rtl/bcd_pkg.sv
// Shared types and constants for the bit-serial BCD adder/subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  // Wraps mod 16, so a digit above 9 maps onto another digit above 9.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal adjust.
// Macro BCD_INVALID_CHECK_EN enables the digit-range flag; otherwise it is tied low.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = sum[3:0];
    cout = 1'b0;
    if (sum > 5'(BCD_MAX)) begin
      s    = 4'(sum + 5'(BCD_ADJ));
      cout = 1'b1;
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  assign invalid = (a > BCD_MAX) || (b > BCD_MAX);
`else
  assign invalid = 1'b0;
`endif

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract: one digit adder reused LSD-first over DIGITS cycles.
// Macro BCD_INVALID_CHECK_EN adds a sticky err flag for operand digits above 9.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Cin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   S,
  output logic                  Cout,
  output logic                  err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [W-1:0]    a_reg, a_next, b_reg, b_next, s_reg, s_next;
  logic            carry_reg, carry_next, sub_reg, sub_next, cout_reg, cout_next;

  bcd_digit_t a_dig [DIGITS];
  bcd_digit_t b_dig [DIGITS];
  bcd_digit_t a_cur, b_cur, b_eff, dig_sum;
  logic       dig_cout, dig_invalid, last_dig;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    assign a_dig[gi] = a_reg[4*gi +: 4];
    assign b_dig[gi] = b_reg[4*gi +: 4];
  end

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDXW'(i)) begin
        a_cur = a_dig[i];
        b_cur = b_dig[i];
      end
    end
    b_eff = sub_reg ? nines_comp(b_cur) : b_cur;
  end

  assign last_dig = (idx_reg == IDXW'(DIGITS - 1));

  bcd_digit_adder u_adder (
    .a       (a_cur),
    .b       (b_eff),
    .cin     (carry_reg),
    .s       (dig_sum),
    .cout    (dig_cout),
    .invalid (dig_invalid)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    carry_next = carry_reg;
    sub_next   = sub_reg;
    cout_next  = cout_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_next     = A;
          b_next     = B;
          sub_next   = sub;
          // Subtraction is A + ninescomp(B) + 1 - borrow.
          carry_next = sub ? ~Cin : Cin;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_reg == IDXW'(i)) s_next[4*i +: 4] = dig_sum;
        end
        carry_next = dig_cout;
        idx_next   = idx_reg + 1'b1;
        if (last_dig) begin
          cout_next  = dig_cout;
          idx_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      carry_reg <= carry_next;
      sub_reg   <= sub_next;
      cout_reg  <= cout_next;
    end
  end

  assign S    = s_reg;
  assign Cout = cout_reg;

`ifdef BCD_INVALID_CHECK_EN
  logic err_reg, err_next;

  always_comb begin
    err_next = err_reg;
    if (state_reg == IDLE && start) err_next = 1'b0;
    else if (state_reg == RUN && dig_invalid) err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= err_next;
  end

  assign err = err_reg;
`else
  // The adder drives invalid low in this build, so err is a constant 0.
  assign err = dig_invalid;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4): vector table, corner sequences, random ops vs decimal model.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = DIGITS + 1;
`ifdef BCD_INVALID_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         ready, done, Cout, err;
  logic [W-1:0] S;

  int compared   = 0;
  int mismatched = 0;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .ready (ready),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer arithmetic, ten's complement on negative differences.
  task automatic model(input logic s_in, input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                       input logic c_in, output logic [W-1:0] s_o, output logic co_o);
    longint m = 1;
    longint r;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    if (!s_in) begin
      r    = bcd2int(a_in) + bcd2int(b_in) + longint'(c_in);
      co_o = (r >= m);
      s_o  = int2bcd(r % m);
    end else begin
      r    = bcd2int(a_in) - bcd2int(b_in) - longint'(c_in);
      co_o = (r >= 0);
      s_o  = int2bcd((r + m) % m);
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Launch one op from IDLE, scramble inputs after acceptance, wait (bounded) for done.
  task automatic do_op(input logic s_in, input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                       input logic c_in, output logic [W-1:0] s_o, output logic co_o,
                       output logic err_o, output int lat);
    @(negedge clk);
    check("ready_before_start", 32'(ready), 32'd1);
    A = a_in; B = b_in; sub = s_in; Cin = c_in; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); sub = ~s_in; Cin = ~c_in;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    s_o = S; co_o = Cout; err_o = err;
  endtask

  vec_t         vecs [10];
  logic [W-1:0] s_got, s_exp;
  logic         co_got, co_exp, err_got;
  int           lat, done_cnt;

  initial begin
    vecs[0] = '{1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h0001, 16'h0002, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0005, 16'h0005, 1'b1, 16'h9999, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h9999, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, CHK};
    vecs[9] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    // Asynchronous reset state, no clock edge needed.
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_S",     32'(S),     32'd0);
    check("rst_Cout",  32'(Cout),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      do_op(vecs[v].sub, vecs[v].a, vecs[v].b, vecs[v].cin, s_got, co_got, err_got, lat);
      $display("vec %0d: sub=%0b %h %h cin=%0b -> S=%h Cout=%0b err=%0b lat=%0d",
               v, vecs[v].sub, vecs[v].a, vecs[v].b, vecs[v].cin, s_got, co_got, err_got, lat);
      check("vec_latency", 32'(lat),     32'(LAT));
      check("vec_S",       32'(s_got),   32'(vecs[v].s));
      check("vec_Cout",    32'(co_got),  32'(vecs[v].cout));
      check("vec_err",     32'(err_got), 32'(vecs[v].err));
      @(negedge clk);
      check("done_one_cycle", 32'(done),  32'd0);
      check("ready_after",    32'(ready), 32'd1);
    end

    // Results hold while idle even though inputs keep changing.
    repeat (3) begin
      @(negedge clk);
      A = W'($urandom); B = W'($urandom);
    end
    check("hold_S",    32'(S),    32'h5555);
    check("hold_Cout", 32'(Cout), 32'd0);

    // Start pulses while busy are ignored; exactly one done.
    @(negedge clk);
    A = 16'h0123; B = 16'h0456; sub = 1'b0; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 2) check("busy_ready", 32'(ready), 32'd0);
      if (c == 2 || c == 3) begin
        A = 16'h9999; B = 16'h9999; sub = 1'b1; Cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    $display("busy: S=%h Cout=%0b done_pulses=%0d", S, Cout, done_cnt);
    check("busy_S",     32'(S),        32'h0579);
    check("busy_Cout",  32'(Cout),     32'd0);
    check("busy_dones", 32'(done_cnt), 32'd1);

    // Reset at RUN digit 2 aborts with no done pulse.
    @(negedge clk);
    A = 16'h4321; B = 16'h1234; sub = 1'b0; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_S",     32'(S),     32'd0);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    do_op(1'b0, 16'h0012, 16'h0034, 1'b0, s_got, co_got, err_got, lat);
    $display("after abort: S=%h Cout=%0b lat=%0d", s_got, co_got, lat);
    check("post_rst_S",   32'(s_got), 32'h0046);
    check("post_rst_lat", 32'(lat),   32'(LAT));

    // Randomized ops against the decimal model.
    for (int n = 0; n < 40; n++) begin
      logic         rs, rc;
      logic [W-1:0] ra, rb;
      rs = 1'($urandom); rc = 1'($urandom);
      ra = rand_bcd();   rb = rand_bcd();
      model(rs, ra, rb, rc, s_exp, co_exp);
      do_op(rs, ra, rb, rc, s_got, co_got, err_got, lat);
      $display("rand %0d: sub=%0b %h %h cin=%0b -> S=%h Cout=%0b (model %h %0b)",
               n, rs, ra, rb, rc, s_got, co_got, s_exp, co_exp);
      check("rand_S",    32'(s_got),   32'(s_exp));
      check("rand_Cout", 32'(co_got),  32'(co_exp));
      check("rand_err",  32'(err_got), 32'd0);
      check("rand_lat",  32'(lat),     32'(LAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
